wand_vector_sequencer: RTL and testbench



---
 rtl/wand_vector_sequencer.sv | 170 +++++++++++++++++
 tb/tb_wand_vector_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wand_vector_sequencer.sv
// Vector sequencer driving a, b, c, d of the 4-input wired-AND block.
// Define WAND_EXPECT_EN to add the registered expected-output port exp_f.
module wand_vector_sequencer #(
  parameter int HOLD_CYCLES = 5,
  parameter int HOLD_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [1:0] mode,
  input  logic       loop,
  input  logic [3:0] user_vec,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       vec_valid,
  output logic [3:0] vec_idx,
  output logic       busy,
`ifdef WAND_EXPECT_EN
  output logic       done,
  output logic       exp_f
`else
  output logic       done
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        mode_q;
  logic              loop_q;
  logic [3:0]        user_q;
  logic [HOLD_W-1:0] cnt;

  logic [1:0]        mode_nxt;
  logic              loop_nxt;
  logic [3:0]        user_nxt;
  logic [HOLD_W-1:0] cnt_nxt;
  logic [3:0]        vec_nxt;
  logic [3:0]        idx_nxt;
  logic              valid_nxt;
  logic              busy_nxt;
  logic              done_nxt;
  logic              last_hold;
  logic              last_idx;

  function automatic logic [3:0] vec_of(
    input logic [1:0] m,
    input logic [3:0] idx,
    input logic [3:0] u
  );
    unique case (m)
      2'b00:   vec_of = idx;
      2'b01:   vec_of = 4'b1000 >> idx;
      2'b10:   vec_of = idx ^ (idx >> 1);
      default: vec_of = u;
    endcase
  endfunction

  function automatic logic [3:0] last_of(input logic [1:0] m);
    unique case (m)
      2'b01:   last_of = 4'd3;
      2'b11:   last_of = 4'd0;
      default: last_of = 4'd15;
    endcase
  endfunction

  assign last_hold = cnt == HOLD_W'(HOLD_CYCLES - 1);
  assign last_idx  = vec_idx == last_of(mode_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mode_q    <= 2'b00;
      loop_q    <= 1'b0;
      user_q    <= 4'b0000;
      cnt       <= '0;
      {a, b, c, d} <= 4'b0000;
      vec_valid <= 1'b0;
      vec_idx   <= 4'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      mode_q    <= mode_nxt;
      loop_q    <= loop_nxt;
      user_q    <= user_nxt;
      cnt       <= cnt_nxt;
      {a, b, c, d} <= vec_nxt;
      vec_valid <= valid_nxt;
      vec_idx   <= idx_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start && !stop) state_nxt = RUN;
      RUN: begin
        if (stop)
          state_nxt = IDLE;
        else if (last_hold && last_idx && !loop_q)
          state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values for every registered output; zero unless a vector is live.
  always_comb begin
    mode_nxt  = mode_q;
    loop_nxt  = loop_q;
    user_nxt  = user_q;
    cnt_nxt   = '0;
    vec_nxt   = 4'b0000;
    idx_nxt   = 4'd0;
    valid_nxt = 1'b0;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !stop) begin
          mode_nxt  = mode;
          loop_nxt  = loop;
          user_nxt  = user_vec;
          vec_nxt   = vec_of(mode, 4'd0, user_vec);
          valid_nxt = 1'b1;
          busy_nxt  = 1'b1;
        end
      end
      RUN: begin
        if (!stop) begin
          valid_nxt = 1'b1;
          busy_nxt  = 1'b1;
          if (!last_hold) begin
            cnt_nxt = cnt + 1'b1;
            idx_nxt = vec_idx;
          end else if (!last_idx) begin
            idx_nxt = 4'(vec_idx + 4'd1);
          end else if (!loop_q) begin
            valid_nxt = 1'b0;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end
          if (valid_nxt)
            vec_nxt = vec_of(mode_q, idx_nxt, user_q);
        end
      end
      default: ;
    endcase
  end

`ifdef WAND_EXPECT_EN
  always_ff @(posedge clk) begin
    if (rst) exp_f <= 1'b0;
    else     exp_f <= (&vec_nxt) & valid_nxt;
  end
`endif

endmodule

// File: tb/tb_wand_vector_sequencer.sv
// Randomized bench for wand_vector_sequencer against a cycle-count model.
// Expected outputs derive from time since the accepted start edge.
module tb_wand_vector_sequencer;

  localparam int H = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stop;
  logic [1:0] mode;
  logic       loop;
  logic [3:0] user_vec;
  logic       a, b, c, d;
  logic       vec_valid;
  logic [3:0] vec_idx;
  logic       busy;
  logic       done;
`ifdef WAND_EXPECT_EN
  logic       exp_f;
`endif

  int nchk = 0;
  int npass = 0;

  wand_vector_sequencer #(.HOLD_CYCLES(H), .HOLD_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .mode     (mode),
    .loop     (loop),
    .user_vec (user_vec),
    .a        (a),
    .b        (b),
    .c        (c),
    .d        (d),
    .vec_valid(vec_valid),
    .vec_idx  (vec_idx),
    .busy     (busy),
`ifdef WAND_EXPECT_EN
    .done     (done),
    .exp_f    (exp_f)
`else
    .done     (done)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] obs();
    return {a, b, c, d, vec_valid, vec_idx, busy, done};
  endfunction

  // Expected {vec, valid, idx, busy, done} t cycles after the start edge.
  function automatic logic [11:0] model(
    input int m, input bit l, input logic [3:0] u, input int t
  );
    int n, k, i;
    logic [3:0] v;
    n = (m == 1) ? 4 : (m == 3) ? 1 : 16;
    k = t / H;
    if (l || k < n) begin
      i = k % n;
      case (m)
        0:       v = i[3:0];
        1:       v = 4'(8 >> i);
        2:       v = 4'(i ^ (i / 2));
        default: v = u;
      endcase
      return {v, 1'b1, i[3:0], 1'b1, 1'b0};
    end
    if (t == n * H) return 12'b0000_0_0000_0_1;
    return 12'd0;
  endfunction

  task automatic start_run(input int m, input bit l, input logic [3:0] u);
    mode = m[1:0];
    loop = l;
    user_vec = u;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    stop = 1'b0;
    mode = 2'b00;
    loop = 1'b0;
    user_vec = 4'hF;
    step();
    step();
    nchk++;
    if (obs() !== 12'd0)
      $display("FAIL reset got=%b exp=%b", obs(), 12'd0);
    else npass++;
    start = 1'b0;
    rst = 1'b0;
    step();
    nchk++;
    if (obs() !== 12'd0)
      $display("FAIL reset_idle got=%b exp=%b", obs(), 12'd0);
    else npass++;
  endtask

  task automatic run_full(input string nm, input int m, input logic [3:0] u);
    int n;
    logic [11:0] e;
    n = (m == 1) ? 4 : (m == 3) ? 1 : 16;
    start_run(m, 1'b0, u);
    for (int t = 0; t <= n * H + 2; t++) begin
      e = model(m, 1'b0, u, t);
      nchk++;
      if (obs() !== e)
        $display("FAIL %s t=%0d got=%b exp=%b", nm, t, obs(), e);
      else npass++;
`ifdef WAND_EXPECT_EN
      nchk++;
      if (exp_f !== ((&e[11:8]) & e[7]))
        $display("FAIL %s_expf t=%0d got=%b exp=%b", nm, t, exp_f,
                 (&e[11:8]) & e[7]);
      else npass++;
`endif
      step();
    end
  endtask

  task automatic test_binary();
    run_full("binary", 0, 4'($urandom));
  endtask

  task automatic test_gray();
    run_full("gray", 2, 4'($urandom));
  endtask

  task automatic test_user();
    run_full("user_1010", 3, 4'b1010);
    run_full("user_rand", 3, 4'($urandom));
  endtask

  task automatic test_walk_loop();
    logic [11:0] e;
    start_run(1, 1'b1, 4'($urandom));
    for (int t = 0; t < 23; t++) begin
      e = model(1, 1'b1, 4'd0, t);
      nchk++;
      if (obs() !== e)
        $display("FAIL walk_loop t=%0d got=%b exp=%b", t, obs(), e);
      else npass++;
      if (t == 22) stop = 1'b1;
      step();
    end
    stop = 1'b0;
    for (int t = 0; t < 3; t++) begin
      nchk++;
      if (obs() !== 12'd0)
        $display("FAIL walk_stop t=%0d got=%b exp=%b", t, obs(), 12'd0);
      else npass++;
      step();
    end
  endtask

  task automatic test_start_stop();
    mode = 2'b00;
    start = 1'b1;
    stop = 1'b1;
    step();
    step();
    start = 1'b0;
    stop = 1'b0;
    nchk++;
    if (obs() !== 12'd0)
      $display("FAIL start_stop got=%b exp=%b", obs(), 12'd0);
    else npass++;
    step();
    nchk++;
    if (obs() !== 12'd0)
      $display("FAIL start_stop_hold got=%b exp=%b", obs(), 12'd0);
    else npass++;
  endtask

  // start, mode, loop and user_vec churn during the run.
  task automatic test_ignored_inputs();
    logic [11:0] e;
    logic [3:0] u;
    int m;
    m = 2 * int'($urandom_range(0, 1));
    u = 4'($urandom);
    start_run(m, 1'b0, u);
    for (int t = 0; t <= 16 * H + 2; t++) begin
      e = model(m, 1'b0, u, t);
      nchk++;
      if (obs() !== e)
        $display("FAIL ignored t=%0d got=%b exp=%b", t, obs(), e);
      else npass++;
      if (t < 16 * H) begin
        start = 1'($urandom);
        mode = 2'($urandom);
        loop = 1'($urandom);
        user_vec = 4'($urandom);
      end else begin
        start = 1'b0;
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] e;
    int m;
    start_run(0, 1'b0, 4'd0);
    for (int t = 0; t < 7 * H; t++) step();
    nchk++;
    if (vec_idx !== 4'd7 || {a, b, c, d} !== 4'b0111)
      $display("FAIL mid_idx got=%0d exp=7", vec_idx);
    else npass++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int t = 0; t < 3; t++) begin
      nchk++;
      if (obs() !== 12'd0)
        $display("FAIL mid_reset t=%0d got=%b exp=%b", t, obs(), 12'd0);
      else npass++;
      step();
    end
    m = int'($urandom_range(0, 3));
    start_run(m, 1'b1, 4'hC);
    for (int t = 0; t < 2 * H + 1; t++) begin
      e = model(m, 1'b1, 4'hC, t);
      nchk++;
      if (obs() !== e)
        $display("FAIL restart t=%0d got=%b exp=%b", t, obs(), e);
      else npass++;
      step();
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic test_random();
    logic [11:0] e;
    logic [3:0] u;
    int m, len;
    bit l;
    for (int r = 0; r < 6; r++) begin
      m = int'($urandom_range(0, 3));
      l = 1'($urandom);
      u = 4'($urandom);
      len = l ? int'($urandom_range(H, 40)) : 16 * H + 2;
      start_run(m, l, u);
      for (int t = 0; t <= len; t++) begin
        e = model(m, l, u, t);
        nchk++;
        if (obs() !== e)
          $display("FAIL rand%0d t=%0d got=%b exp=%b", r, t, obs(), e);
        else npass++;
        if (l && t == len) stop = 1'b1;
        step();
      end
      stop = 1'b0;
      nchk++;
      if (obs() !== 12'd0)
        $display("FAIL rand%0d_end got=%b exp=%b", r, obs(), 12'd0);
      else npass++;
      step();
    end
  endtask

  initial begin
    test_reset();
    test_binary();
    test_walk_loop();
    test_gray();
    test_user();
    test_start_stop();
    test_ignored_inputs();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
